// File: rtl/mvau_weight_loader.sv
// Weight-stream loader for the MVAU per-PE weight memories: word i is written
// to PE (i mod PE) at address (i div PE), one cycle after its handshake.
module mvau_weight_loader #(
    parameter int PE           = 2,
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_wgt_v,
    output logic                    in_wgt_r,
    input  logic [SIMD*TW-1:0]      in_wgt,
    output logic [PE-1:0]           wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata
);

    localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [1:0]              state_reg, state_next;
    logic [PE_BW-1:0]        pe_cnt_reg, pe_cnt_next;
    logic [WMEM_ADDR_BW-1:0] addr_cnt_reg, addr_cnt_next;
    logic [PE-1:0]           we_reg, we_next;
    logic [WMEM_ADDR_BW-1:0] waddr_reg, waddr_next;
    logic [SIMD*TW-1:0]      wdata_reg, wdata_next;

    logic          handshake;
    logic          last_word;
    logic [PE-1:0] pe_onehot;

    // Ready is a pure state decode so it never loops back through in_wgt_v.
    assign busy      = (state_reg == S_LOAD);
    assign in_wgt_r  = (state_reg == S_LOAD);
    assign done      = (state_reg == S_DONE);
    assign handshake = in_wgt_v & in_wgt_r;
    assign last_word = (pe_cnt_reg == PE_LAST) && (addr_cnt_reg == ADDR_LAST);

    generate
        for (genvar gi = 0; gi < PE; gi++) begin : g_onehot
            assign pe_onehot[gi] = (pe_cnt_reg == PE_BW'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        pe_cnt_next   = pe_cnt_reg;
        addr_cnt_next = addr_cnt_reg;
        we_next       = '0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_LOAD;
                    pe_cnt_next   = '0;
                    addr_cnt_next = '0;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    we_next    = pe_onehot;
                    waddr_next = addr_cnt_reg;
                    wdata_next = in_wgt;
                    if (last_word) begin
                        state_next    = S_DONE;
                        pe_cnt_next   = '0;
                        addr_cnt_next = '0;
                    end else if (pe_cnt_reg == PE_LAST) begin
                        pe_cnt_next   = '0;
                        addr_cnt_next = addr_cnt_reg + WMEM_ADDR_BW'(1);
                    end else begin
                        pe_cnt_next = pe_cnt_reg + PE_BW'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Reset also clears we_reg, so a write captured just before reset never lands.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            pe_cnt_reg   <= '0;
            addr_cnt_reg <= '0;
            we_reg       <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pe_cnt_reg   <= pe_cnt_next;
            addr_cnt_reg <= addr_cnt_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
        end
    end

    assign wmem_we    = we_reg;
    assign wmem_waddr = waddr_reg;
    assign wmem_wdata = wdata_reg;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader with PE=2, SIMD=4, TW=2, WMEM_DEPTH=3.
module tb_mvau_weight_loader;

    localparam int PE           = 2;
    localparam int SIMD         = 4;
    localparam int TW           = 2;
    localparam int WMEM_DEPTH   = 3;
    localparam int WMEM_ADDR_BW = 2;
    localparam int DW           = SIMD * TW;

    logic                    aclk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    in_wgt_v;
    logic                    in_wgt_r;
    logic [DW-1:0]           in_wgt;
    logic [PE-1:0]           wmem_we;
    logic [WMEM_ADDR_BW-1:0] wmem_waddr;
    logic [DW-1:0]           wmem_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-computed write pattern for 6 words: PE alternates, address every 2 words.
    logic [1:0] exp_we   [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    int         exp_addr [6] = '{0, 0, 1, 1, 2, 2};

    mvau_weight_loader #(
        .PE(PE), .SIMD(SIMD), .TW(TW),
        .WMEM_DEPTH(WMEM_DEPTH), .WMEM_ADDR_BW(WMEM_ADDR_BW)
    ) dut (
        .aclk(aclk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_wgt_v(in_wgt_v), .in_wgt_r(in_wgt_r), .in_wgt(in_wgt),
        .wmem_we(wmem_we), .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " ready"}, 32'(in_wgt_r), 32'd0);
        check({tag, " we"}, 32'(wmem_we), 32'd0);
    endtask

    task automatic check_write(input string tag, input int k, input logic [DW-1:0] data);
        $display("%s write %0d: we=%b addr=%0d data=%h", tag, k, wmem_we, wmem_waddr, wmem_wdata);
        check($sformatf("%s we[%0d]", tag, k), 32'(wmem_we), 32'(exp_we[k]));
        check($sformatf("%s waddr[%0d]", tag, k), 32'(wmem_waddr), 32'(exp_addr[k]));
        check($sformatf("%s wdata[%0d]", tag, k), 32'(wmem_wdata), 32'(data));
        check($sformatf("%s done[%0d]", tag, k), 32'(done), (k == 5) ? 32'd1 : 32'd0);
        check($sformatf("%s ready[%0d]", tag, k), 32'(in_wgt_r), (k == 5) ? 32'd0 : 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [DW-1:0] base);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            in_wgt_v = 1'b1;
            in_wgt   = base + DW'(k);
            step();
            check_write(tag, k, base + DW'(k));
        end
    endtask

    initial begin
        int k;
        int writes;

        // 1. reset defaults
        rst = 1'b1; start = 1'b0; in_wgt_v = 1'b0; in_wgt = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle($sformatf("rst%0d", c));
            check("rst waddr", 32'(wmem_waddr), 32'd0);
            check("rst wdata", 32'(wmem_wdata), 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_idle($sformatf("idle%0d", c));
        end

        // 2. back-to-back load, then 6. overflow guard
        do_load("b2b", 8'h10);
        for (int c = 0; c < 5; c++) begin
            in_wgt_v = 1'b1;
            in_wgt   = 8'hEE;
            step();
            check_idle($sformatf("ovf%0d", c));
        end
        in_wgt_v = 1'b0;

        // 3. bubbled stream
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            in_wgt_v = (c % 2 == 0);
            in_wgt   = in_wgt_v ? (8'hA0 + DW'(k)) : 8'hFF;
            step();
            if (c % 2 == 0) begin
                check_write("bub", k, 8'hA0 + DW'(k));
                k++;
            end else begin
                check($sformatf("bub gap%0d we", c), 32'(wmem_we), 32'd0);
                check($sformatf("bub gap%0d waddr", c), 32'(wmem_waddr), 32'(exp_addr[k-1]));
                check($sformatf("bub gap%0d wdata", c), 32'(wmem_wdata), 32'(8'hA0 + DW'(k - 1)));
            end
        end
        in_wgt_v = 1'b0;
        step();
        check_idle("bub end");

        // 4. mid-load reset
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_wgt_v = 1'b1;
            in_wgt   = 8'h20 + DW'(j);
            step();
            check_write("mid", j, 8'h20 + DW'(j));
        end
        rst = 1'b1; in_wgt = 8'h23;
        step();
        rst = 1'b0; in_wgt_v = 1'b0;
        check_idle("mid rst");
        check("mid rst waddr", 32'(wmem_waddr), 32'd0);
        check("mid rst wdata", 32'(wmem_wdata), 32'd0);
        step();
        check_idle("mid after");
        do_load("reload", 8'h30);
        in_wgt_v = 1'b0;
        step();

        // 5. spurious start during load and on the done cycle
        writes = 0;
        start = 1'b1;
        step();
        for (int j = 0; j < 6; j++) begin
            in_wgt_v = 1'b1;
            in_wgt   = 8'h50 + DW'(j);
            step();
            if (wmem_we != '0) writes++;
            check_write("spur", j, 8'h50 + DW'(j));
        end
        step();
        if (wmem_we != '0) writes++;
        start = 1'b0; in_wgt_v = 1'b0;
        check_idle("spur post");
        for (int c = 0; c < 3; c++) begin
            step();
            if (wmem_we != '0) writes++;
            check_idle($sformatf("spur idle%0d", c));
        end
        check("spur writes", 32'(writes), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
